// File: rtl/sr_bank_pkg.sv
// Shared encodings for the SR flop bank: simultaneous-assert rules and the
// active-low {S_n,R_n} pair values.
package sr_bank_pkg;

  localparam int PRI_HOLD   = 0;
  localparam int PRI_SET    = 1;
  localparam int PRI_RESET  = 2;
  localparam int PRI_TOGGLE = 3;

  typedef enum logic [1:0] {
    PAIR_BOTH = 2'b00,
    PAIR_SET  = 2'b01,
    PAIR_RST  = 2'b10,
    PAIR_IDLE = 2'b11
  } pair_e;

  function automatic int cnt_width(input int filter);
    return (filter < 1) ? 1 : $clog2(filter + 1);
  endfunction

endpackage

// File: rtl/sr_chan.sv
// One SR channel: input pair glitch filter, set/reset/priority action,
// registered complementary Q/Qbar, change pulse and sticky err bit.
module sr_chan
  import sr_bank_pkg::*;
#(
  parameter int   FILTER   = 2,
  parameter int   PRIORITY = PRI_HOLD,
  parameter logic INIT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s_n,
  input  logic r_n,
  input  logic clr_err,
  output logic q,
  output logic qbar,
  output logic change,
  output logic err
);

  localparam int            CW      = cnt_width(FILTER);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER);
  localparam logic [CW-1:0] CNT_THR = CW'((FILTER > 0) ? FILTER - 1 : 0);
  localparam logic          NO_FILT = (FILTER == 0);

  pair_e         raw;
  pair_e         cand;
  logic [CW-1:0] cnt;
  logic          match;
  logic          qual;
  logic          held;
  logic          fresh;
  logic          q_nxt;
  logic          err_set;

  assign raw = pair_e'({s_n, r_n});

  // A pair is already held when it was qualified on the previous edge too
  // (count saturated); only the first qualifying edge is "fresh".
  always_comb begin
    match   = (raw == cand);
    qual    = NO_FILT || (match && (cnt >= CNT_THR));
    held    = match && (cnt == CNT_MAX);
    fresh   = qual && !held;
    q_nxt   = q;
    err_set = fresh && (raw == PAIR_BOTH);
    if (qual) begin
      case (raw)
        PAIR_SET: q_nxt = 1'b1;
        PAIR_RST: q_nxt = 1'b0;
        PAIR_BOTH: begin
          case (PRIORITY)
            PRI_SET:    q_nxt = 1'b1;
            PRI_RESET:  q_nxt = 1'b0;
            PRI_TOGGLE: q_nxt = fresh ? ~q : q;
            default:    q_nxt = q;
          endcase
        end
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand   <= PAIR_IDLE;
      cnt    <= '0;
      q      <= INIT;
      qbar   <= ~INIT;
      change <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (!match) begin
        cand <= raw;
        cnt  <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      q      <= q_nxt;
      qbar   <= ~q_nxt;
      change <= (q_nxt != q);
      err    <= err_set | (err & ~clr_err);
    end
  end

endmodule

// File: rtl/sr_flop_bank.sv
// Bank of CHANNELS independent clocked SR storage elements with active-low
// set/reset inputs, glitch filtering and a selectable simultaneous-assert rule.
module sr_flop_bank
  import sr_bank_pkg::*;
#(
  parameter int                  CHANNELS = 4,
  parameter int                  FILTER   = 2,
  parameter int                  PRIORITY = PRI_HOLD,
  parameter logic [CHANNELS-1:0] INIT     = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] S_n,
  input  logic [CHANNELS-1:0] R_n,
  input  logic                clr_err,
  output logic [CHANNELS-1:0] Q,
  output logic [CHANNELS-1:0] Qbar,
  output logic [CHANNELS-1:0] change,
  output logic [CHANNELS-1:0] err
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    sr_chan #(
      .FILTER  (FILTER),
      .PRIORITY(PRIORITY),
      .INIT    (INIT[i])
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .s_n    (S_n[i]),
      .r_n    (R_n[i]),
      .clr_err(clr_err),
      .q      (Q[i]),
      .qbar   (Qbar[i]),
      .change (change[i]),
      .err    (err[i])
    );
  end

endmodule

// File: tb/tb_sr_flop_bank.sv
// Directed self-checking bench for sr_flop_bank across several parameter sets.
module tb_sr_flop_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_err;
  logic [3:0] s_n [6];
  logic [3:0] r_n [6];
  logic [3:0] q   [6];
  logic [3:0] qb  [6];
  logic [3:0] chg [6];
  logic [3:0] er  [6];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // 0: filtered bank; 1..4: unfiltered, PRIORITY 0..3; 5: FILTER=3
  sr_flop_bank #(.CHANNELS(4), .FILTER(2), .PRIORITY(0), .INIT(4'b1010)) u_a (
    .clk(clk), .rst(rst), .S_n(s_n[0]), .R_n(r_n[0]), .clr_err(clr_err),
    .Q(q[0]), .Qbar(qb[0]), .change(chg[0]), .err(er[0]));
  sr_flop_bank #(.CHANNELS(4), .FILTER(0), .PRIORITY(0), .INIT(4'b0000)) u_p0 (
    .clk(clk), .rst(rst), .S_n(s_n[1]), .R_n(r_n[1]), .clr_err(clr_err),
    .Q(q[1]), .Qbar(qb[1]), .change(chg[1]), .err(er[1]));
  sr_flop_bank #(.CHANNELS(4), .FILTER(0), .PRIORITY(1), .INIT(4'b0000)) u_p1 (
    .clk(clk), .rst(rst), .S_n(s_n[2]), .R_n(r_n[2]), .clr_err(clr_err),
    .Q(q[2]), .Qbar(qb[2]), .change(chg[2]), .err(er[2]));
  sr_flop_bank #(.CHANNELS(4), .FILTER(0), .PRIORITY(2), .INIT(4'b0000)) u_p2 (
    .clk(clk), .rst(rst), .S_n(s_n[3]), .R_n(r_n[3]), .clr_err(clr_err),
    .Q(q[3]), .Qbar(qb[3]), .change(chg[3]), .err(er[3]));
  sr_flop_bank #(.CHANNELS(4), .FILTER(0), .PRIORITY(3), .INIT(4'b0000)) u_p3 (
    .clk(clk), .rst(rst), .S_n(s_n[4]), .R_n(r_n[4]), .clr_err(clr_err),
    .Q(q[4]), .Qbar(qb[4]), .change(chg[4]), .err(er[4]));
  sr_flop_bank #(.CHANNELS(4), .FILTER(3), .PRIORITY(0), .INIT(4'b0000)) u_r (
    .clk(clk), .rst(rst), .S_n(s_n[5]), .R_n(r_n[5]), .clr_err(clr_err),
    .Q(q[5]), .Qbar(qb[5]), .change(chg[5]), .err(er[5]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input int d, input logic [3:0] exp_q,
                         input logic [3:0] exp_chg);
    check({tag, ".Q"}, q[d], exp_q);
    check({tag, ".Qbar"}, qb[d], ~exp_q);
    check({tag, ".change"}, chg[d], exp_chg);
  endtask

  initial begin
    rst = 1'b1;
    clr_err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_n[i] = 4'hF;
      r_n[i] = 4'hF;
    end

    // Reset held for two edges
    tick();
    tick();
    check_q("reset_a", 0, 4'b1010, 4'b0000);
    check("reset_a.err", er[0], 4'b0000);
    check_q("reset_r", 5, 4'b0000, 4'b0000);
    rst = 1'b0;

    // FILTER=2: two-sample set glitch is ignored
    s_n[0] = 4'b1110;
    tick(); check_q("glitch_e1", 0, 4'b1010, 4'b0000);
    tick(); check_q("glitch_e2", 0, 4'b1010, 4'b0000);
    s_n[0] = 4'b1111;
    tick(); check_q("glitch_end", 0, 4'b1010, 4'b0000);
    // held set takes effect on the third edge
    s_n[0] = 4'b1110;
    tick(); check_q("filt_e1", 0, 4'b1010, 4'b0000);
    tick(); check_q("filt_e2", 0, 4'b1010, 4'b0000);
    tick(); check_q("filt_e3", 0, 4'b1011, 4'b0001);
    tick(); check_q("filt_e4", 0, 4'b1011, 4'b0000);
    check("filt.err", er[0], 4'b0000);
    s_n[0] = 4'b1111;

    // Preset ch1 to 1 on the hold and reset-dominant banks
    s_n[1] = 4'b1101;
    s_n[3] = 4'b1101;
    tick();
    check_q("preset_p0", 1, 4'b0010, 4'b0010);
    check_q("preset_p2", 3, 4'b0010, 4'b0010);
    s_n[1] = 4'b1111;
    s_n[3] = 4'b1111;
    tick();

    // Simultaneous assert on ch1, held for four edges
    for (int d = 1; d <= 4; d++) begin
      s_n[d] = 4'b1101;
      r_n[d] = 4'b1101;
    end
    tick();
    check_q("both_p0_e1", 1, 4'b0010, 4'b0000);
    check_q("both_p1_e1", 2, 4'b0010, 4'b0010);
    check_q("both_p2_e1", 3, 4'b0000, 4'b0010);
    check_q("both_p3_e1", 4, 4'b0010, 4'b0010);
    for (int e = 2; e <= 4; e++) begin
      tick();
      check_q($sformatf("both_p0_e%0d", e), 1, 4'b0010, 4'b0000);
      check_q($sformatf("both_p1_e%0d", e), 2, 4'b0010, 4'b0000);
      check_q($sformatf("both_p2_e%0d", e), 3, 4'b0000, 4'b0000);
      check_q($sformatf("both_p3_e%0d", e), 4, 4'b0010, 4'b0000);
    end
    for (int d = 1; d <= 4; d++) check($sformatf("both_err_p%0d", d - 1), er[d], 4'b0010);
    for (int d = 1; d <= 4; d++) begin
      s_n[d] = 4'hF;
      r_n[d] = 4'hF;
    end
    tick();
    check_q("both_release_p3", 4, 4'b0010, 4'b0000);

    // Toggle retrigger: 00, 11, 00
    s_n[4] = 4'b1101; r_n[4] = 4'b1101;
    tick(); check_q("tog_e1", 4, 4'b0000, 4'b0010);
    s_n[4] = 4'b1111; r_n[4] = 4'b1111;
    tick(); check_q("tog_e2", 4, 4'b0000, 4'b0000);
    s_n[4] = 4'b1101; r_n[4] = 4'b1101;
    tick(); check_q("tog_e3", 4, 4'b0010, 4'b0010);
    s_n[4] = 4'b1111; r_n[4] = 4'b1111;
    tick(); check_q("tog_e4", 4, 4'b0010, 4'b0000);

    // err clear on hold bank, ch2
    s_n[1] = 4'b1011; r_n[1] = 4'b1011;
    tick(); check("errset", er[1], 4'b0110);
    check_q("errset_q", 1, 4'b0010, 4'b0000);
    s_n[1] = 4'b1111; r_n[1] = 4'b1111;
    clr_err = 1'b1;
    tick(); check("errclr", er[1], 4'b0000);
    s_n[1] = 4'b1011; r_n[1] = 4'b1011;
    tick(); check("errclr_vs_set", er[1], 4'b0100);
    clr_err = 1'b0;
    s_n[1] = 4'b1111; r_n[1] = 4'b1111;
    tick(); check("err_sticky", er[1], 4'b0100);

    // FILTER=3: reset mid-filter discards progress
    s_n[5] = 4'b1110;
    tick(); tick();
    check_q("rmid_pre", 5, 4'b0000, 4'b0000);
    rst = 1'b1;
    tick();
    check_q("rmid_rst", 5, 4'b0000, 4'b0000);
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check_q($sformatf("rmid_e%0d", e), 5, 4'b0000, 4'b0000);
    end
    tick(); check_q("rmid_e4", 5, 4'b0001, 4'b0001);
    tick(); check_q("rmid_e5", 5, 4'b0001, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_flop_bank.md
Name: sr_flop_bank

Overview:
- Parametrised, clocked successor to the team's cross-coupled NAND SR latch.
- CHANNELS independent SR storage elements. Each has active-low set/reset inputs (NAND-latch polarity), a per-channel input glitch filter and a selectable rule for simultaneous set/reset.
- Used as a bank of sticky status/control bits with a guaranteed complementary Q/Qbar pair. It never produces the Q=Qbar=1 state.

Parameters:
- CHANNELS, 4, number of independent SR channels (>=1).
- FILTER, 2, extra consecutive stable samples required before an input pair takes effect (0 = no filtering).
- PRIORITY, 0, simultaneous-assert rule: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
- INIT, {CHANNELS{1'b0}}, per-channel Q value after reset.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- S_n  input  CHANNELS  active-low set request per channel
- R_n  input  CHANNELS  active-low reset request per channel
- clr_err  input  1  clears all err bits
- Q  output  CHANNELS  stored state
- Qbar  output  CHANNELS  always ~Q, registered alongside Q
- change  output  CHANNELS  one-cycle pulse when the channel's Q changed on this edge
- err  output  CHANNELS  sticky flag: both S_n and R_n were filtered-active together

Behaviour:
- Reset (rst=1 at a clk edge): Q=INIT, Qbar=~INIT, change=0, err=0, filter candidate=2'b11 (idle), filter count=0. Reset overrides all other inputs on that edge.
- Filter, per channel: the raw pair {S_n,R_n} is compared to the stored candidate at each edge.
  - Mismatch: candidate<=raw, count<=0.
  - Match with count<FILTER: count increments.
  - The pair is "qualified" on the edge where it has been sampled equal on FILTER+1 consecutive edges, and stays qualified while it is unchanged.
  - FILTER=0: every sampled pair is qualified on its first edge.
- Latency: a pair applied before edge k and held updates Q at edge k+FILTER. Q, Qbar and change are visible after that edge.
- Qualified pair actions:
  - 11: hold.
  - 01 (set): Q<=1.
  - 10 (reset): Q<=0.
  - 00 (both): action per PRIORITY.
- PRIORITY on a qualified 00:
  - 0: hold.
  - 1: Q<=1.
  - 2: Q<=0.
  - 3: Q<=~Q exactly once, on the edge the 00 pair first becomes qualified. A held 00 does not re-toggle. A fresh toggle needs a different pair in between, then 00 requalified.
- err[i] is set on the edge a 00 pair becomes qualified on channel i, for all PRIORITY values.
- clr_err=1 clears all err bits on that edge. If a set event and clr_err coincide on the same channel, set wins (err stays 1).
- change[i]=1 for exactly the cycle following an edge where Q[i] changed value. It is 0 when Q is rewritten with the same value.
- Channels are fully independent. No cross-channel priority.
- A glitch shorter than FILTER+1 samples leaves Q, change and err untouched, and it restarts the filter count.
- Reset mid-filter discards partial counts. After rst deasserts, a held input needs FILTER+1 fresh samples before it takes effect.
- Count width: $clog2(FILTER+1), minimum 1 bit. The count saturates at FILTER and never wraps.

Decomposition:
- Package sr_bank_pkg:
  - PRIORITY encodings as localparams: PRI_HOLD=0, PRI_SET=1, PRI_RESET=2, PRI_TOGGLE=3.
  - Pair encodings: PAIR_IDLE=2'b11, PAIR_SET=2'b01, PAIR_RST=2'b10, PAIR_BOTH=2'b00.
- Sub-module sr_chan: one channel (filter, action logic, Q, change, err bit).
- sr_flop_bank instantiates CHANNELS copies of sr_chan in a generate loop and shares clk, rst and clr_err.

Test Plan:
1. Reset: CHANNELS=4, INIT=4'b1010, rst high for 2 edges -> Q=4'b1010, Qbar=4'b0101, err=0, change=0.
2. Filter, FILTER=2: ch0 S_n low for 2 edges, then high -> Q[0] stays 0, change=0. Then S_n low held -> Q[0]=1 after the 3rd edge, change[0] pulses one cycle.
3. Priority, FILTER=0, hold S_n=R_n=0 on ch1 for 4 edges:
   - PRIORITY=0: Q unchanged.
   - PRIORITY=1: Q[1]=1.
   - PRIORITY=2: Q[1]=0.
   - PRIORITY=3: Q[1] toggles once only.
   - In every case err[1]=1.
4. Toggle retrigger, PRIORITY=3, FILTER=0: pairs 00,11,00 on consecutive edges -> Q toggles twice, with 2 change pulses.
5. err clear: err[2]=1; clr_err with no event -> err[2]=0. clr_err in the same cycle as a qualified 00 -> err[2] stays 1.
6. Reset mid-operation: FILTER=3, set held 2 edges, then rst 1 edge, set still held -> Q=INIT until the 4th post-reset edge, after which Q=1.
